// File: rtl/unsigned_seq_divider.sv
// Purpose : iterative unsigned restoring divider (shift-subtract), one quotient bit per cycle.
// Latency : WIDTH+1 edges from accepted start to done (done high the cycle after edge N+WIDTH);
//           divide-by-zero completes one cycle after acceptance.
// Backpr. : none; start is honoured only in IDLE/DONE, ignored while busy (caller must wait for done).
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset; aborts any operation in flight
//   start        request pulse, accepted in IDLE or DONE
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse when results are valid
//   quotient     result quotient, holds until the next operation completes or reset
//   remainder    result remainder, holds like quotient
//   div_by_zero  set with done when the captured divisor was zero
module unsigned_seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;

    // rq: [2W:W] partial remainder (one guard bit), [W-1:0] dividend shifting out / quotient shifting in.
    logic [2*WIDTH:0]   rq_q, rq_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    // Datapath for one restoring step.
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH:0]   rq_step;
    logic               last_iter;
    logic               accept;
    logic               divisor_zero;

    always_comb begin
        shifted = {rq_q[2*WIDTH-1:0], 1'b0};
        // Subtract at WIDTH+1 bits: the shifted partial remainder can exceed 2^WIDTH-1
        // when the divisor has its top bit set, so the guard bit must take part.
        trial   = shifted[2*WIDTH:WIDTH] - {1'b0, dsr_q};
        if (!trial[WIDTH]) begin
            // No borrow: keep the difference and shift a 1 into the quotient.
            rq_step = {trial, shifted[WIDTH-1:1], 1'b1};
        end else begin
            // Borrow: restore by keeping the plain shifted value (quotient bit 0).
            rq_step = shifted;
        end
    end

    assign last_iter    = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign divisor_zero = (divisor == '0);

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (divisor_zero) begin
                        // Short-circuit: no iterations, report saturated quotient.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rq_d    = {{(WIDTH + 1){1'b0}}, dividend};
                        dsr_d   = divisor;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                rq_d  = rq_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    // Take results from the post-update value so the final bit is included.
                    quo_d   = rq_step[WIDTH-1:0];
                    rem_d   = rq_step[2*WIDTH-1:WIDTH];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rq_q    <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_seq_divider.sv
// Purpose : scoreboard bench for unsigned_seq_divider (directed vectors plus random pairs).
// Latency : expects done WIDTH+1 edges after accept, one edge for divide-by-zero.
// Backpr. : stimulus waits for done before issuing the next request.
module tb_unsigned_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    unsigned_seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 q=%0h r=%0h", quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",    64'(quotient),    64'(e.q));
                    chk("remainder",   64'(remainder),   64'(e.r));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    if (!e.dbz) begin
                        chk("invariant", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
                        chk("rem_lt_div", 64'(remainder < e.b), 64'd1);
                    end
                end
            end
        end
    end

    // Called at a negedge n0 negedges after the one following the accept edge.
    task automatic wait_done(input int n0, input int exp_n);
        int n;
        n = n0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(exp_n));
    endtask

    // Caller is at a negedge; leaves the bench at the negedge where done is high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk("busy_after_accept", 64'(busy), dbz ? 64'd0 : 64'd1);
        wait_done(0, dbz ? 0 : W);
    endtask

    task automatic run_model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) run_op(a, b, '1, a, 1'b1);
        else         run_op(a, b, a / b, a % b, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int n;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy),        64'd0);
        chk("rst_done",  64'(done),        64'd0);
        chk("rst_quo",   64'(quotient),    64'd0);
        chk("rst_rem",   64'(remainder),   64'd0);
        chk("rst_dbz",   64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);           @(negedge clk);
        run_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0); @(negedge clk);
        run_op(32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0); @(negedge clk);
        run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);             @(negedge clk);
        run_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);       @(negedge clk);
        run_op(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);              @(negedge clk);
        run_op(32'h80000000, 32'd3, 32'd715827882, 32'd2, 1'b0); @(negedge clk);

        // Start during CALC is ignored; start in DONE is accepted back-to-back.
        sb.push_back('{a: 32'd100, b: 32'd7, q: 32'd14, r: 32'd2, dbz: 1'b0});
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignores_start", 64'(busy), 64'd1);
        wait_done(10, W);
        run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);             // issued in the DONE cycle
        run_op(32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 1'b1);        // back-to-back into divide-by-zero
        @(negedge clk);

        // Reset in the middle of CALC aborts without a done.
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy),        64'd0);
        chk("abort_done", 64'(done),        64'd0);
        chk("abort_quo",  64'(quotient),    64'd0);
        chk("abort_rem",  64'(remainder),   64'd0);
        chk("abort_dbz",  64'(div_by_zero), 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(32'd9, 32'd4, 32'd2, 32'd1, 1'b0);              @(negedge clk);

        // Random pairs against the reference model.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd1;
                1: b = a;
                2: begin
                    a = 32'($urandom_range(0, 1000));
                    b = a + 32'($urandom_range(1, 1000));
                end
                3: b = (i % 4 == 0) ? 32'd0 : 32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_model(a, b);
            @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
